// File: rtl/fifo_rd_ctrl_if.sv
// rtl/fifo_rd_ctrl_if.sv - FIFO read side and consumer handshake bundle for fifo_rd_ctrl
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_busy;

  modport master (
    input  rempty, rdata, tx_busy,
    output rinc, tx_data, tx_valid
  );

  modport slave (
    output rempty, rdata, tx_busy,
    input  rinc, tx_data, tx_valid
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - pops bytes from a FIFO and hands them to a busy-handshaked consumer
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 enable,
  input  logic                 err_clr,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] sent_count,
  output logic                 ctrl_busy,
  fifo_rd_ctrl_if.master       bus
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state;
  logic [TW-1:0]         tmo_cnt;
  logic                  rinc_q;
  logic                  tx_valid_q;
  logic [DATA_WIDTH-1:0] tx_data_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      rinc_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      timeout_err <= 1'b0;
      sent_count  <= '0;
    end else begin
      // Clear first so a timeout set later in this block takes priority.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !bus.rempty && !bus.tx_busy) begin
            state      <= ISSUE;
            tx_data_q  <= bus.rdata;
            tx_valid_q <= 1'b1;
            rinc_q     <= 1'b1;
          end
        end
        ISSUE: begin
          tx_valid_q <= 1'b0;
          rinc_q     <= 1'b0;
          tmo_cnt    <= '0;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.tx_busy) begin
            state      <= WAIT_DONE;
            sent_count <= sent_count + CNT_WIDTH'(1);
          end else if (tmo_cnt == TMO_LAST) begin
            // Consumer never acknowledged; the popped byte is dropped.
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctrl_busy    = (state != IDLE);
  assign bus.rinc     = rinc_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        enable;
  logic        err_clr;
  logic        timeout_err;
  logic [15:0] sent_count;
  logic        ctrl_busy;

  fifo_rd_ctrl_if #(.DATA_WIDTH(8)) bus ();

  fifo_rd_ctrl #(
    .DATA_WIDTH  (8),
    .ACK_TIMEOUT (15),
    .CNT_WIDTH   (16)
  ) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .enable      (enable),
    .err_clr     (err_clr),
    .timeout_err (timeout_err),
    .sent_count  (sent_count),
    .ctrl_busy   (ctrl_busy),
    .bus         (bus)
  );

  always #5 rclk = ~rclk;

  int vectors        = 0;
  int miscompares    = 0;
  int cyc            = 0;
  int rinc_cnt       = 0;
  int valid_cnt      = 0;
  int last_valid_cyc = 0;
  int spacing        = 0;
  logic [7:0] q[$];
  logic [7:0] burst_b[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_fifo();
    bus.rempty = (q.size() == 0);
    bus.rdata  = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  // One clock: sample #1 after the edge, log pulses, and let the FIFO model pop on rinc.
  task automatic step();
    @(posedge rclk);
    #1;
    cyc++;
    if (bus.tx_valid === 1'b1) begin
      valid_cnt++;
      spacing        = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (bus.rinc === 1'b1) begin
      rinc_cnt++;
      if (q.size() > 0) void'(q.pop_front());
      upd_fifo();
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (bus.tx_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(bus.tx_valid), 1);
  endtask

  // Consumer raises busy one cycle after tx_valid and holds it n cycles.
  task automatic consume(input int n);
    step();
    bus.tx_busy = 1'b1;
    repeat (n) step();
    bus.tx_busy = 1'b0;
  endtask

  initial begin
    rrst_n      = 1'b0;
    enable      = 1'b0;
    err_clr     = 1'b0;
    bus.tx_busy = 1'b0;
    burst_b     = '{8'h11, 8'h22, 8'h33};
    upd_fifo();
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_rinc", 32'(bus.rinc), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_sent_count", 32'(sent_count), 0);
    chk("rst_ctrl_busy", 32'(ctrl_busy), 0);
    rrst_n = 1'b1;

    // Single byte
    enable = 1'b1;
    step();
    q.push_back(8'hA5);
    upd_fifo();
    rinc_cnt = 0; valid_cnt = 0;
    wait_valid("single", 5);
    chk("single_rinc", 32'(bus.rinc), 1);
    chk("single_tx_data", 32'(bus.tx_data), 32'hA5);
    chk("single_ctrl_busy", 32'(ctrl_busy), 1);
    step();
    chk("single_valid_clear", 32'(bus.tx_valid), 0);
    chk("single_rinc_clear", 32'(bus.rinc), 0);
    bus.tx_busy = 1'b1;
    step();
    chk("single_sent_count", 32'(sent_count), 1);
    repeat (9) step();
    bus.tx_busy = 1'b0;
    chk("single_busy_hold", 32'(ctrl_busy), 1);
    step();
    chk("single_idle", 32'(ctrl_busy), 0);
    repeat (3) step();
    chk("single_rinc_total", 32'(rinc_cnt), 1);
    chk("single_valid_total", 32'(valid_cnt), 1);

    // Burst of three, consumer busy 10 cycles each
    rinc_cnt = 0;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    upd_fifo();
    for (int i = 0; i < 3; i++) begin
      wait_valid("burst", 20);
      chk("burst_tx_data", 32'(bus.tx_data), 32'(burst_b[i]));
      if (i > 0) chk("burst_spacing_ge4", 32'(spacing >= 4), 1);
      consume(10);
    end
    repeat (6) step();
    chk("burst_rinc_total", 32'(rinc_cnt), 3);
    chk("burst_sent_count", 32'(sent_count), 4);
    chk("burst_rempty", 32'(bus.rempty), 1);

    // Minimum spacing with a one-cycle consumer
    q.push_back(8'h01); q.push_back(8'h02);
    upd_fifo();
    wait_valid("min_sp1", 5);
    consume(1);
    wait_valid("min_sp2", 10);
    chk("min_spacing_eq4", 32'(spacing), 4);
    chk("min_sp_tx_data", 32'(bus.tx_data), 32'h02);
    consume(1);
    repeat (3) step();
    chk("min_sp_sent_count", 32'(sent_count), 6);

    // Timeout, then err_clr
    q.push_back(8'h99);
    upd_fifo();
    wait_valid("tmo", 5);
    repeat (15) step();
    chk("tmo_still_busy", 32'(ctrl_busy), 1);
    chk("tmo_err_not_yet", 32'(timeout_err), 0);
    step();
    chk("tmo_idle", 32'(ctrl_busy), 0);
    chk("tmo_err_set", 32'(timeout_err), 1);
    chk("tmo_sent_count", 32'(sent_count), 6);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("tmo_err_cleared", 32'(timeout_err), 0);

    // Timeout coinciding with err_clr: set wins
    q.push_back(8'h9A);
    upd_fifo();
    wait_valid("tmo2", 5);
    repeat (15) step();
    err_clr = 1'b1;
    step();
    chk("tmo2_set_wins", 32'(timeout_err), 1);
    step();
    chk("tmo2_cleared", 32'(timeout_err), 0);
    err_clr = 1'b0;

    // Enable drop after tx_valid
    rinc_cnt = 0;
    q.push_back(8'h44); q.push_back(8'h55);
    upd_fifo();
    wait_valid("en_drop", 5);
    step();
    enable = 1'b0;
    bus.tx_busy = 1'b1;
    repeat (10) step();
    bus.tx_busy = 1'b0;
    repeat (8) step();
    chk("en_drop_rinc", 32'(rinc_cnt), 1);
    chk("en_drop_idle", 32'(ctrl_busy), 0);
    chk("en_drop_sent", 32'(sent_count), 7);
    enable = 1'b1;
    wait_valid("en_resume", 5);
    chk("en_resume_data", 32'(bus.tx_data), 32'h55);
    consume(10);
    repeat (3) step();
    chk("en_resume_sent", 32'(sent_count), 8);

    // Reset during WAIT_DONE
    q.push_back(8'h66);
    upd_fifo();
    wait_valid("rst_mid", 5);
    step();
    bus.tx_busy = 1'b1;
    step();
    chk("rst_mid_pre_busy", 32'(ctrl_busy), 1);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl_busy", 32'(ctrl_busy), 0);
    chk("rst_mid_tx_data", 32'(bus.tx_data), 0);
    chk("rst_mid_sent", 32'(sent_count), 0);
    chk("rst_mid_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_mid_rinc", 32'(bus.rinc), 0);
    repeat (2) step();
    rrst_n = 1'b1;
    rinc_cnt = 0;
    q.push_back(8'h77);
    upd_fifo();
    repeat (3) step();
    chk("rst_rel_no_pop", 32'(rinc_cnt), 0);
    bus.tx_busy = 1'b0;
    step();
    chk("rst_rel_valid", 32'(bus.tx_valid), 1);
    chk("rst_rel_data", 32'(bus.tx_data), 32'h77);
    consume(10);
    repeat (3) step();
    chk("rst_rel_sent", 32'(sent_count), 1);

    // Counter wrap
    force dut.sent_count = 16'hFFFF;
    #1;
    release dut.sent_count;
    chk("wrap_preload", 32'(sent_count), 32'hFFFF);
    q.push_back(8'h88);
    upd_fifo();
    wait_valid("wrap", 5);
    consume(3);
    repeat (2) step();
    chk("wrap_sent", 32'(sent_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of FIFO read data and of tx_data.
REQ-002 Parameter ACK_TIMEOUT, default 15: maximum number of cycles to wait for tx_busy to rise after a tx_valid pulse.
REQ-003 Parameter CNT_WIDTH, default 16: width of sent_count.
REQ-004 rclk  in  1  sole clock, rising edge.
REQ-005 rrst_n  in  1  asynchronous reset, active low.
REQ-006 enable  in  1  level; 1 permits new FIFO pops.
REQ-007 rempty  in  1  FIFO empty flag, same clock domain.
REQ-008 rdata  in  DATA_WIDTH  FIFO read data at the current read address, valid while rempty=0.
REQ-009 rinc  out  1  FIFO pop strobe, registered, one-cycle pulse.
REQ-010 tx_busy  in  1  consumer (serializer) busy level.
REQ-011 tx_data  out  DATA_WIDTH  registered byte presented to the consumer.
REQ-012 tx_valid  out  1  registered one-cycle data-valid pulse to the consumer.
REQ-013 err_clr  in  1  synchronous clear of timeout_err.
REQ-014 timeout_err  out  1  sticky flag: the consumer failed to acknowledge within ACK_TIMEOUT cycles.
REQ-015 sent_count  out  CNT_WIDTH  count of bytes acknowledged by the consumer.
REQ-016 ctrl_busy  out  1  1 whenever the state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_ACK and WAIT_DONE, each encoded in 2 bits.
REQ-018 IDLE -> ISSUE SHALL occur at an edge where enable=1, rempty=0 and tx_busy=0; at that edge tx_data<=rdata, tx_valid<=1 and rinc<=1.
REQ-019 In ISSUE, tx_valid and rinc SHALL each be high for exactly this one cycle; at the next edge both clear and the state goes to WAIT_ACK with the timeout counter set to 0.
REQ-020 In WAIT_ACK, tx_busy=1 SHALL move the state to WAIT_DONE and increment sent_count by 1, modulo 2^CNT_WIDTH, with wrap from all-ones to 0.
REQ-021 In WAIT_ACK, the timeout counter SHALL increment each cycle while tx_busy=0.
REQ-022 When the counter equals ACK_TIMEOUT-1 and tx_busy=0, the next state SHALL be IDLE, timeout_err<=1 and sent_count SHALL be unchanged; the popped byte is dropped.
REQ-023 In WAIT_DONE, tx_busy=0 SHALL move the state to IDLE; otherwise the FSM remains in WAIT_DONE indefinitely.
REQ-024 Back-to-back bytes: the minimum spacing between tx_valid pulses SHALL be 4 cycles (ISSUE, WAIT_ACK, WAIT_DONE, IDLE).
REQ-025 rinc SHALL never be asserted while rempty=0 is not sampled in the same decision cycle; there is at most one rinc per tx_valid, and rinc and tx_valid are always coincident.
REQ-026 Deasserting enable outside IDLE SHALL NOT abort the transfer; the current byte completes and the FSM then rests in IDLE.
REQ-027 rempty rising outside IDLE SHALL be ignored until the FSM returns to IDLE.
REQ-028 err_clr=1 SHALL clear timeout_err at the next edge.
REQ-029 If a timeout occurs in the same cycle as err_clr=1, the set SHALL win.
REQ-030 Sizing: the timeout counter width is clog2(ACK_TIMEOUT)+1 bits; ACK_TIMEOUT >= 2.
REQ-031 ctrl_busy SHALL be decoded from the state register only.

Reset
REQ-032 Asserting rrst_n=0 at any time, including mid-transfer, SHALL immediately force the following, with no pending pop or valid retained: state=IDLE, rinc=0, tx_valid=0, tx_data=0, timeout_err=0, sent_count=0, timeout counter=0, ctrl_busy=0.
REQ-033 After rrst_n deasserts, the first pop SHALL occur no earlier than the first rising edge at which the IDLE conditions of REQ-018 hold.

Verification
REQ-034 Single byte: rdata=8'hA5, rempty 1->0, enable=1; tx_busy rises 1 cycle after tx_valid and is held for 10 cycles -> one rinc/tx_valid pulse with tx_data=8'hA5, sent_count=1, ctrl_busy back to 0 one cycle after tx_busy falls.
REQ-035 Burst: 3 bytes 11/22/33 queued, consumer busy 10 cycles each -> exactly 3 pulses in order, spacing >= 4 cycles, sent_count=3, no pop after rempty=1.
REQ-036 Timeout: tx_busy stuck 0 after tx_valid -> return to IDLE after 15 WAIT_ACK cycles, timeout_err=1, sent_count unchanged; err_clr pulse -> timeout_err=0.
REQ-037 Enable drop: enable 1->0 in the cycle after tx_valid with 2 bytes queued -> first byte completes, no further rinc while enable=0; re-enable -> second byte issued.
REQ-038 Reset mid-transfer: rrst_n=0 during WAIT_DONE -> all outputs at reset values within the same cycle, no rinc after release until the REQ-018 conditions hold.
REQ-039 Wrap: preload to sent_count=16'hFFFF via 65535 transfers (or force) and send one byte -> sent_count=16'h0000.
